// File: rtl/latency_rx_checker.sv
// Receive-side latency checker: measures timer minus embedded ingress stamp per packet and keeps statistics.
// Optional seqnum continuity tracking is enabled by defining LATENCY_RX_SEQ_CHECK_EN.
module latency_rx_checker #(
  parameter int unsigned TS_WIDTH     = 28,
  parameter int unsigned SUM_WIDTH    = 48,
  parameter int unsigned CNT_WIDTH    = 32,
  parameter int unsigned IDLE_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [31:0]          in_tdata,
  input  logic [127:0]         in_tuser,
  input  logic                 in_tlast,
  input  logic                 in_tvalid,
  output logic                 in_tready,
  input  logic [63:0]          timer,
  output logic [TS_WIDTH-1:0]  lat_last,
  output logic [TS_WIDTH-1:0]  lat_min,
  output logic [TS_WIDTH-1:0]  lat_max,
  output logic [SUM_WIDTH-1:0] lat_sum,
  output logic [CNT_WIDTH-1:0] pkt_count,
  output logic [15:0]          seq_err_count,
  output logic [15:0]          timeout_count,
  output logic                 result_stb
);

  localparam int unsigned WD_W      = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam int unsigned SUM_EXT_W = SUM_WIDTH + 1;
  localparam int unsigned SEQ_W     = 12;

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_UPDATE, S_DISCARD} state_e;

  state_e               state_q, state_d;
  logic [WD_W-1:0]      wd_q, wd_d, wd_inc_c;
  logic [TS_WIDTH-1:0]  lat_cap_q, lat_cap_d, lat_meas_c;
  logic [TS_WIDTH-1:0]  lat_last_q, lat_last_d, lat_min_q, lat_min_d, lat_max_q, lat_max_d;
  logic [SUM_WIDTH-1:0] lat_sum_q, lat_sum_d;
  logic [SUM_EXT_W-1:0] sum_ext_c;
  logic [CNT_WIDTH-1:0] pkt_count_q, pkt_count_d;
  logic [15:0]          timeout_count_q, timeout_count_d;
  logic                 accept_c, timeout_c, first_beat_c;
  logic                 unused_bits_c;

  assign accept_c     = in_tvalid && in_tready;
  assign first_beat_c = (state_q == S_IDLE) && accept_c;
  assign wd_inc_c     = wd_q + WD_W'(1);
  assign timeout_c    = (IDLE_TIMEOUT != 0) && (state_q == S_RECV) && !accept_c &&
                        (wd_inc_c == WD_W'(IDLE_TIMEOUT));
  // Modular subtraction keeps the result correct across timer wrap.
  assign lat_meas_c   = timer[TS_WIDTH-1:0] - TS_WIDTH'(in_tuser[55:28]);
  assign sum_ext_c    = {1'b0, lat_sum_q} + SUM_EXT_W'(lat_cap_q);
  assign unused_bits_c = ^{in_tdata, in_tuser, timer};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          if (clear) state_d = in_tlast ? S_IDLE : S_DISCARD;
          else       state_d = in_tlast ? S_UPDATE : S_RECV;
        end
      end
      S_RECV: begin
        if (clear)                     state_d = (accept_c && in_tlast) ? S_IDLE : S_DISCARD;
        else if (accept_c && in_tlast) state_d = S_UPDATE;
        else if (timeout_c)            state_d = S_DISCARD;
      end
      S_UPDATE:  state_d = S_IDLE;
      S_DISCARD: if (accept_c && in_tlast) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_tready  = (state_q != S_UPDATE);
    result_stb = (state_q == S_UPDATE) && !clear;
  end

  always_comb begin
    wd_d            = '0;
    lat_cap_d       = lat_cap_q;
    lat_last_d      = lat_last_q;
    lat_min_d       = lat_min_q;
    lat_max_d       = lat_max_q;
    lat_sum_d       = lat_sum_q;
    pkt_count_d     = pkt_count_q;
    timeout_count_d = timeout_count_q;
    if (state_q == S_RECV && !accept_c) wd_d = wd_inc_c;
    if (first_beat_c) lat_cap_d = lat_meas_c;
    if (result_stb) begin
      lat_last_d = lat_cap_q;
      if (lat_cap_q < lat_min_q) lat_min_d = lat_cap_q;
      if (lat_cap_q > lat_max_q) lat_max_d = lat_cap_q;
      lat_sum_d = sum_ext_c[SUM_WIDTH] ? '1 : sum_ext_c[SUM_WIDTH-1:0];
      if (pkt_count_q != '1) pkt_count_d = pkt_count_q + CNT_WIDTH'(1);
    end
    if (timeout_c && timeout_count_q != '1) timeout_count_d = timeout_count_q + 16'd1;
    if (clear) begin
      lat_last_d      = '0;
      lat_min_d       = '1;
      lat_max_d       = '0;
      lat_sum_d       = '0;
      pkt_count_d     = '0;
      timeout_count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_q            <= '0;
      lat_cap_q       <= '0;
      lat_last_q      <= '0;
      lat_min_q       <= '1;
      lat_max_q       <= '0;
      lat_sum_q       <= '0;
      pkt_count_q     <= '0;
      timeout_count_q <= '0;
    end else begin
      wd_q            <= wd_d;
      lat_cap_q       <= lat_cap_d;
      lat_last_q      <= lat_last_d;
      lat_min_q       <= lat_min_d;
      lat_max_q       <= lat_max_d;
      lat_sum_q       <= lat_sum_d;
      pkt_count_q     <= pkt_count_d;
      timeout_count_q <= timeout_count_d;
    end
  end

`ifdef LATENCY_RX_SEQ_CHECK_EN
  // First packet after reset/clear only arms; expected seqnum always resyncs to seq + 1.
  logic [SEQ_W-1:0] seq_cap_q, seq_cap_d, exp_q, exp_d;
  logic             armed_q, armed_d;
  logic [15:0]      seq_err_q, seq_err_d;

  always_comb begin
    seq_cap_d = seq_cap_q;
    exp_q_hold: begin end
    exp_d     = exp_q;
    armed_d   = armed_q;
    seq_err_d = seq_err_q;
    if (first_beat_c) seq_cap_d = in_tuser[123:112];
    if (result_stb) begin
      if (armed_q && seq_cap_q != exp_q && seq_err_q != '1) seq_err_d = seq_err_q + 16'd1;
      exp_d   = seq_cap_q + SEQ_W'(1);
      armed_d = 1'b1;
    end
    if (clear) begin
      armed_d   = 1'b0;
      seq_err_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_cap_q <= '0;
      exp_q     <= '0;
      armed_q   <= 1'b0;
      seq_err_q <= '0;
    end else begin
      seq_cap_q <= seq_cap_d;
      exp_q     <= exp_d;
      armed_q   <= armed_d;
      seq_err_q <= seq_err_d;
    end
  end

  assign seq_err_count = seq_err_q;
`else
  assign seq_err_count = '0;
`endif

  assign lat_last      = lat_last_q;
  assign lat_min       = lat_min_q;
  assign lat_max       = lat_max_q;
  assign lat_sum       = lat_sum_q;
  assign pkt_count     = pkt_count_q;
  assign timeout_count = timeout_count_q;

endmodule
